// File: rtl/ws_sta_output_drain.sv
// Deskews the systolic array's staggered outputC lanes into whole rows and
// buffers them in a small FIFO; rows that find the FIFO full are dropped.

module ws_sta_lane_dly #(
  parameter int W   = 21,
  parameter int DLY = 1
) (
  input  logic         clock,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  if (DLY == 0) begin : g_thru
    assign q = d;
  end else begin : g_sr
    logic [DLY-1:0][W-1:0] sr_q, sr_d;

    always_comb begin
      sr_d    = sr_q;
      sr_d[0] = d;
      for (int k = 1; k < DLY; k++) sr_d[k] = sr_q[k-1];
    end

    // Pure data path: only the valid pipe carries meaning, so no reset here.
    always_ff @(posedge clock) sr_q <= sr_d;

    assign q = sr_q[DLY-1];
  end
endmodule

module ws_sta_output_drain #(
  parameter int N     = 32,
  parameter int W     = 21,
  parameter int DEPTH = 4,
  parameter int ROWS  = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [N*W-1:0]             in_c,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N*W-1:0]             out_row,
  output logic                       out_last,
  output logic                       overflow,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;

  // Lane c arrives c cycles late, so it waits N-1-c more to line up with lane N-1.
  logic [N-1:0][W-1:0] lane_al;

  for (genvar c = 0; c < N; c++) begin : g_lane
    ws_sta_lane_dly #(.W(W), .DLY(N-1-c)) u_lane (
      .clock (clock),
      .d     (in_c[c*W +: W]),
      .q     (lane_al[c])
    );
  end

  logic [N-1:1] vld_pipe_q, vld_pipe_d;
  logic         aligned_vld;

  always_comb begin
    vld_pipe_d    = vld_pipe_q;
    vld_pipe_d[1] = in_valid;
    for (int k = 2; k < N; k++) vld_pipe_d[k] = vld_pipe_q[k-1];
  end

  assign aligned_vld = vld_pipe_q[N-1];

  logic [N*W-1:0] mem_q [DEPTH];
  logic [N*W-1:0] wr_data_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]  level_q, level_d;
  logic [CW-1:0]  row_cnt_q, row_cnt_d;
  logic           ovf_q, ovf_d;
  logic           full, pop, push, drop;

  always_comb begin
    out_valid = (level_q != '0);
    full      = (level_q == LW'(DEPTH));
    pop       = out_valid & out_ready;
    // A pop in the same edge frees the slot, so a full FIFO can still accept.
    push      = aligned_vld & (~full | pop);
    drop      = aligned_vld & full & ~pop;
    wr_data_d = lane_al;
    wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d   = level_q + LW'(push) - LW'(pop);
    row_cnt_d = row_cnt_q;
    if (pop) row_cnt_d = (row_cnt_q == CW'(ROWS-1)) ? '0 : row_cnt_q + CW'(1);
    ovf_d     = ovf_q | drop;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_pipe_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      row_cnt_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      row_cnt_q  <= row_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_d;
  end

  assign out_row  = mem_q[rd_ptr_q];
  assign out_last = out_valid & (row_cnt_q == CW'(ROWS-1));
  assign overflow = ovf_q;
  assign level    = level_q;
endmodule

// File: tb/tb_ws_sta_output_drain.sv
// Directed bench for ws_sta_output_drain: skewed row injection, queue-level
// reference model compared every cycle, plus literal spot checks per scenario.

module tb_ws_sta_output_drain;
  localparam int N = 32, W = 21, DEPTH = 4, ROWS = 32;
  localparam int LW = $clog2(DEPTH+1);
  localparam int DW = N*W;
  localparam int MAXC = 4096;

  logic          clock, reset, in_valid, out_ready, out_valid, out_last, overflow;
  logic [DW-1:0] in_c, out_row;
  logic [LW-1:0] level;

  int cyc = 0;
  int errors = 0, checks = 0;
  bit chk_en = 0;

  bit            sched_v   [MAXC];
  logic [DW-1:0] sched_row [MAXC];

  ws_sta_output_drain #(.N(N), .W(W), .DEPTH(DEPTH), .ROWS(ROWS)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_c      (in_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row),
    .out_last  (out_last),
    .overflow  (overflow),
    .level     (level)
  );

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] mk_row(input int base);
    logic [DW-1:0] r;
    for (int c = 0; c < N; c++) r[c*W +: W] = W'(base + c);
    return r;
  endfunction

  task automatic sched(input int e, input logic [DW-1:0] d);
    sched_v[e]   = 1'b1;
    sched_row[e] = d;
  endtask

  // Advance to the falling edge that follows rising edge number e.
  task automatic wait_to(input int e);
    while (cyc <= e) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Skewed driver: lane c carries the row whose in_valid was at edge e-c; junk otherwise.
  initial begin
    in_valid = 1'b0;
    in_c     = '0;
    forever begin
      @(negedge clock);
      in_valid = (cyc < MAXC) ? sched_v[cyc] : 1'b0;
      for (int c = 0; c < N; c++) begin
        if (cyc >= c && cyc - c < MAXC && sched_v[cyc-c])
          in_c[c*W +: W] = sched_row[cyc-c][c*W +: W];
        else
          in_c[c*W +: W] = W'($urandom);
      end
    end
  end

  // Reference: rows in flight land N-1 edges after in_valid; FIFO is a queue.
  typedef struct { int arr; logic [DW-1:0] d; } fl_t;
  fl_t           fl[$];
  logic [DW-1:0] mq[$];
  int            mcnt = 0;
  bit            movf = 0;
  bit            m_pop;
  fl_t           m_ent;

  initial begin
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        fl.delete();
        mq.delete();
        mcnt = 0;
        movf = 0;
      end else begin
        m_pop = (mq.size() > 0) && out_ready;
        if (m_pop) begin
          void'(mq.pop_front());
          mcnt = (mcnt + 1) % ROWS;
        end
        if (fl.size() > 0 && fl[0].arr == cyc) begin
          m_ent = fl.pop_front();
          if (mq.size() < DEPTH) mq.push_back(m_ent.d);
          else movf = 1;
        end
        if (in_valid) begin
          m_ent.arr = cyc + N - 1;
          m_ent.d   = sched_row[cyc];
          fl.push_back(m_ent);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      #1;
      if (chk_en) begin
        chk("out_valid", DW'(out_valid), DW'(mq.size() > 0));
        chk("level", DW'(level), DW'(mq.size()));
        chk("overflow", DW'(overflow), DW'(movf));
        chk("out_last", DW'(out_last), DW'((mq.size() > 0) && mcnt == ROWS-1));
        if (mq.size() > 0) chk("out_row", out_row, mq[0]);
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got no completion expected finish before 200000");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  int e0, nv, nl, lastpos;

  initial begin
    reset = 1'b0;
    out_ready = 1'b0;
    #2 reset = 1'b1;
    chk_en = 1'b1;
    #1;
    chk("rst_valid", DW'(out_valid), '0);
    chk("rst_level", DW'(level), '0);
    chk("rst_ovf", DW'(overflow), '0);
    chk("rst_last", DW'(out_last), '0);
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Single row, latency and content
    out_ready = 1'b1;
    e0 = cyc + 2;
    sched(e0, mk_row(1));
    wait_to(e0 + N - 2);
    chk("single_early", DW'(out_valid), '0);
    wait_to(e0 + N - 1);
    chk("single_valid", DW'(out_valid), DW'(1));
    chk("single_lane0", DW'(out_row[0 +: W]), DW'(1));
    chk("single_lane31", DW'(out_row[31*W +: W]), DW'(32));
    chk("single_level", DW'(level), DW'(1));
    wait_to(e0 + N);
    chk("single_gone", DW'(out_valid), '0);
    chk("single_level0", DW'(level), '0);

    // Stream of one full tile
    do_reset();
    out_ready = 1'b1;
    e0 = cyc + 2;
    for (int r = 0; r < 32; r++) sched(e0 + r, mk_row(r * 32));
    wait_to(e0 + N - 2);
    nv = 0; nl = 0; lastpos = -1;
    repeat (36) begin
      @(negedge clock);
      if (out_valid) begin
        if (out_last) begin nl++; lastpos = nv; end
        nv++;
      end
    end
    chk("stream_count", DW'(nv), DW'(32));
    chk("stream_lasts", DW'(nl), DW'(1));
    chk("stream_lastpos", DW'(lastpos), DW'(31));

    // Backpressure and drop
    do_reset();
    out_ready = 1'b0;
    e0 = cyc + 2;
    for (int r = 0; r < 5; r++) sched(e0 + r, mk_row(1000 * (r + 1)));
    wait_to(e0 + 3 + N - 1);
    chk("bp_level4", DW'(level), DW'(4));
    chk("bp_noovf", DW'(overflow), '0);
    wait_to(e0 + 4 + N - 1);
    chk("bp_level_full", DW'(level), DW'(4));
    chk("bp_ovf", DW'(overflow), DW'(1));
    chk("bp_head", out_row, mk_row(1000));
    out_ready = 1'b1;
    @(negedge clock);
    chk("bp_next", out_row, mk_row(2000));
    repeat (5) @(negedge clock);
    chk("bp_drained", DW'(level), '0);
    chk("bp_ovf_sticky", DW'(overflow), DW'(1));

    // Full FIFO with a pop on the aligned-write edge
    do_reset();
    out_ready = 1'b0;
    e0 = cyc + 2;
    for (int r = 0; r < 5; r++) sched(e0 + r, mk_row(5000 + 100 * r));
    wait_to(e0 + 4 + N - 2);
    chk("fp_level_pre", DW'(level), DW'(4));
    out_ready = 1'b1;
    wait_to(e0 + 4 + N - 1);
    out_ready = 1'b0;
    chk("fp_noovf", DW'(overflow), '0);
    chk("fp_level", DW'(level), DW'(4));
    chk("fp_head", out_row, mk_row(5100));
    out_ready = 1'b1;
    repeat (6) @(negedge clock);
    chk("fp_drained", DW'(level), '0);

    // Reset while a row is half aligned
    do_reset();
    out_ready = 1'b1;
    e0 = cyc + 2;
    sched(e0, mk_row(3000));
    wait_to(e0 + 9);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    nv = 0;
    repeat (N + 5) begin
      @(negedge clock);
      if (out_valid) nv++;
    end
    chk("mid_rst_novalid", DW'(nv), '0);
    chk("mid_rst_ovf", DW'(overflow), '0);
    chk("mid_rst_level", DW'(level), '0);

    // Hold under back-pressure with junk on the inputs
    do_reset();
    out_ready = 1'b0;
    e0 = cyc + 2;
    sched(e0, mk_row(7000));
    wait_to(e0 + N - 1);
    repeat (10) begin
      chk("hold_valid", DW'(out_valid), DW'(1));
      chk("hold_row", out_row, mk_row(7000));
      chk("hold_last", DW'(out_last), '0);
      @(negedge clock);
    end
    out_ready = 1'b1;
    repeat (3) @(negedge clock);
    chk("hold_released", DW'(level), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ws_sta_output_drain.md
WS_STA_OUTPUT_DRAIN -- requirements
Module: ws_sta_output_drain

Interface
REQ-001 SHALL have parameter N, default 32: number of array columns (outputC lanes).
REQ-002 SHALL have parameter W, default 21: width of one outputC lane.
REQ-003 SHALL have parameter DEPTH, default 4: row FIFO depth, power of two, >=2.
REQ-004 SHALL have parameter ROWS, default 32: rows per tile, used for out_last.
REQ-005 SHALL have port clock  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port in_valid  input  1  lane 0 of in_c carries a new row this cycle.
REQ-008 SHALL have port in_c  input  N*W  array outputC lanes, lane c at bits [c*W +: W], skewed.
REQ-009 SHALL have port out_valid  output  1  aligned row available.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the row.
REQ-011 SHALL have port out_row  output  N*W  deskewed row, lane c at [c*W +: W].
REQ-012 SHALL have port out_last  output  1  out_row is row ROWS-1 of the current tile.
REQ-013 SHALL have port overflow  output  1  sticky: at least one aligned row was dropped.
REQ-014 SHALL have port level  output  $clog2(DEPTH+1)  current FIFO occupancy.

Function
REQ-015 SHALL treat the array outputs as skewed: for a row with in_valid sampled at edge E0, lane c holds that row's value at edge E0+c.
REQ-016 SHALL deskew by delaying lane c by N-1-c cycles and in_valid by N-1 cycles, so the full row is aligned at edge E0+N-1.
REQ-017 SHALL accept back-to-back rows: in_valid may be high every cycle, and each row is tracked independently through the delay line.
REQ-018 SHALL write the aligned row into the FIFO at edge E0+N-1; with the FIFO empty, out_valid is high in the cycle after that edge (latency N edges from in_valid to visible out_valid).
REQ-019 SHALL pop one row per edge where out_valid and out_ready are both high; out_row and out_last are stable while out_valid is high and out_ready is low.
REQ-020 SHALL output rows in arrival order; row values are passed unmodified (no arithmetic, no width change).
REQ-021 SHALL, when the FIFO is full and out_ready is high in the cycle of an aligned write, pop and write in the same edge; level stays DEPTH and no drop occurs.
REQ-022 SHALL, when the FIFO is full and no pop occurs in the cycle of an aligned write, drop the incoming row and set overflow, because the array cannot be back-pressured.
REQ-023 SHALL write without drop when the FIFO is empty and a pop coincides; empty FIFO never asserts out_valid combinationally from the delay line.
REQ-024 SHALL keep an output row counter 0..ROWS-1, advanced on each pop and wrapping to 0 after ROWS-1; out_last = out_valid and (counter == ROWS-1).
REQ-025 SHALL not advance the row counter for dropped rows.
REQ-026 SHALL keep overflow high until reset once set.
REQ-027 SHALL ignore in_c contents on lanes whose delayed valid is low; X on in_c when in_valid is low never reaches out_row under out_valid.

Reset
REQ-028 SHALL, on reset assertion, immediately clear: out_valid=0, out_last=0, overflow=0, level=0, the row counter, FIFO pointers, and all delay-line valid bits.
REQ-029 SHALL discard every in-flight partially aligned row on reset mid-operation; no row sampled before reset deassertion ever appears on out_row.
REQ-030 SHALL not require clearing of the data storage; only valid and control state is reset.
REQ-031 SHALL sample in_valid normally on the first rising edge after reset deassertion.

Verification
REQ-032 Single row: reset, then at E0 in_valid=1, lane c gets c+1 at edge E0+c, out_ready=1 -> out_valid high for one cycle after E0+31 with lane c = c+1, level returns to 0.
REQ-033 Stream: 32 back-to-back rows, row r lane c = r*32+c, out_ready=1 -> 32 consecutive out_valid cycles in order, out_last only on row 31, counter back to 0.
REQ-034 Backpressure: out_ready=0, 4 rows in -> level=4, overflow=0; 5th row -> dropped, overflow=1, level=4; out_ready=1 -> rows 0..3 out in order, overflow stays 1.
REQ-035 Full with simultaneous pop: level=4, out_ready=1 on the aligned-write cycle of row 5 -> no drop, overflow=0, level=4.
REQ-036 Reset mid-flight: in_valid at E0, reset asserted at E0+10 for 2 cycles -> out_valid never rises for that row; overflow=0, level=0.
REQ-037 Hold: out_valid=1, out_ready=0 for 10 cycles with new in_c traffic on invalid cycles -> out_row and out_last unchanged throughout.
